johnson_decoder: RTL and testbench

//  - Receive-side monitor/decoder for a Johnson counter's N-bit state vector.
//  - Samples the code, converts it to a binary index and a one-hot phase, and checks legality.
//  - Tracks step-to-step sequence, locks after consecutive good steps, and flags/counts errors.
//  - Sits beside the Johnson counter; consumers use idx/onehot as phase selects.

---
 rtl/johnson_pkg.sv | 48 ++++
 rtl/johnson_code_decode.sv | 25 ++
 rtl/johnson_decoder.sv | 164 ++++++++++++++++
 tb/tb_johnson_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson counter decoder.
// N is the counter width (2N states); the decoder and its code helpers are
// sized from it, so a different width is set here.
//   state_t  : lock FSM states
//   IDX_W    : width of a count index 0..2N-1
//   jc2idx   : Johnson code -> index (assumes a legal code)
//   idx2jc   : index -> Johnson code
//   jc_legal : code is one of the 2N legal Johnson codes
package johnson_pkg;

  localparam int N     = 4;
  localparam int MOD   = 2 * N;
  localparam int IDX_W = $clog2(2 * N);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  // MSB set: ones fill from the MSB, index is the popcount.
  // MSB clear: ones drain toward bit 0, index counts back from 2N.
  function automatic logic [IDX_W-1:0] jc2idx(input logic [N-1:0] jc);
    int p;
    p = 0;
    for (int b = 0; b < N; b++) p += int'(jc[b]);
    if (jc[N-1])     return IDX_W'(p);
    else if (p == 0) return '0;
    else             return IDX_W'(MOD - p);
  endfunction

  function automatic logic [N-1:0] idx2jc(input logic [IDX_W-1:0] idx);
    logic [N-1:0] c;
    int           i;
    i = int'(idx);
    c = '0;
    for (int b = 0; b < N; b++) begin
      if (i <= N) c[b] = (b >= N - i);
      else        c[b] = (b < MOD - i);
    end
    return c;
  endfunction

  // A code is legal exactly when it survives a round trip through its index.
  function automatic logic jc_legal(input logic [N-1:0] jc);
    return (idx2jc(jc2idx(jc)) == jc);
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code decoder.
//   i_jc     : sampled Johnson code, bit N-1 = MSB
//   o_legal  : code is a legal Johnson code
//   o_idx    : count index 0..2N-1 (0 when illegal)
//   o_onehot : one-hot phase, bit o_idx set (all zero when illegal)
module johnson_code_decode
  import johnson_pkg::*;
(
  input  logic [N-1:0]     i_jc,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_idx,
  output logic [MOD-1:0]   o_onehot
);

  always_comb begin
    o_legal  = jc_legal(i_jc);
    o_idx    = '0;
    o_onehot = '0;
    if (o_legal) begin
      o_idx           = jc2idx(i_jc);
      o_onehot[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Receive-side monitor for a Johnson counter: decodes each valid sample,
// checks step continuity, locks after LOCK_CNT consecutive good samples and
// counts errors seen while locked. All outputs are registered.
//
// Optional feature: define JOHNSON_DEC_RECOVER_EN to add o_fix_rst /
// o_fix_preset, active-low per-flop clear/preset strobes that reload the
// counter with the expected next code when a locked step goes bad.
//
// Ports:
//   i_clk, i_rst_n  : clock (rising edge), async active-low reset
//   i_jc, i_jc_vld  : Johnson code sample and its valid
//   o_out_vld       : i_jc_vld delayed one cycle
//   o_idx/o_onehot/o_legal : decode of the last valid sample
//   o_locked        : FSM in LOCKED
//   o_err           : 1-cycle pulse, bad sample while LOCKED
//   o_wrap          : 1-cycle pulse, good step 2N-1 -> 0
//   o_err_cnt       : saturating error count
//
// state    | meaning
// UNLOCKED | counting consecutive good samples in r_run
// LOCKED   | sequence trusted; a bad sample raises err and drops lock
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_jc,
  input  logic             i_jc_vld,
  output logic             o_out_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic [MOD-1:0]   o_onehot,
  output logic             o_legal,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_wrap,
  output logic [ERR_W-1:0] o_err_cnt
`ifdef JOHNSON_DEC_RECOVER_EN
  ,
  output logic [N-1:0]     o_fix_rst,
  output logic [N-1:0]     o_fix_preset
`endif
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [MOD-1:0]   w_onehot;
  logic [IDX_W-1:0] w_prev_nxt;
  logic             w_good;

  state_t           r_state;
  logic [RUN_W-1:0] r_run;
  logic [IDX_W-1:0] r_prev;
  logic             r_prev_vld;
  logic             r_out_vld;
  logic [IDX_W-1:0] r_idx;
  logic [MOD-1:0]   r_onehot;
  logic             r_legal;
  logic             r_err;
  logic             r_wrap;
  logic [ERR_W-1:0] r_err_cnt;
`ifdef JOHNSON_DEC_RECOVER_EN
  logic [N-1:0]     r_fix_rst;
  logic [N-1:0]     r_fix_preset;
`endif

  johnson_code_decode u_decode (
    .i_jc     (i_jc),
    .o_legal  (w_legal),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // 2N need not be a power of two, so wrap the successor explicitly.
  assign w_prev_nxt = (r_prev == IDX_W'(MOD - 1)) ? '0 : r_prev + 1'b1;
  // Holding the same phase counts as good; with no history any legal code is.
  assign w_good = w_legal &&
                  (!r_prev_vld || (w_idx == w_prev_nxt) || (w_idx == r_prev));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= UNLOCKED;
      r_run        <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_out_vld    <= 1'b0;
      r_idx        <= '0;
      r_onehot     <= '0;
      r_legal      <= 1'b0;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
      r_err_cnt    <= '0;
`ifdef JOHNSON_DEC_RECOVER_EN
      r_fix_rst    <= '1;
      r_fix_preset <= '1;
`endif
    end else begin
      r_out_vld    <= i_jc_vld;
      r_err        <= 1'b0;
      r_wrap       <= 1'b0;
`ifdef JOHNSON_DEC_RECOVER_EN
      r_fix_rst    <= '1;
      r_fix_preset <= '1;
`endif
      if (i_jc_vld) begin
        r_idx    <= w_idx;
        r_onehot <= w_onehot;
        r_legal  <= w_legal;
        r_wrap   <= w_good && r_prev_vld &&
                    (r_prev == IDX_W'(MOD - 1)) && (w_idx == '0);
        if (w_legal) begin
          r_prev     <= w_idx;
          r_prev_vld <= 1'b1;
        end
        case (r_state)
          UNLOCKED: begin
            if (w_good) begin
              if (int'(r_run) + 1 >= LOCK_CNT) begin
                r_run   <= RUN_W'(LOCK_CNT);
                r_state <= LOCKED;
              end else begin
                r_run <= r_run + 1'b1;
              end
            end else begin
              r_run <= '0;
            end
          end
          LOCKED: begin
            if (!w_good) begin
              r_err   <= 1'b1;
              r_run   <= '0;
              r_state <= UNLOCKED;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
`ifdef JOHNSON_DEC_RECOVER_EN
              // Bits that must be 1 get preset, bits that must be 0 get cleared.
              r_fix_preset <= ~idx2jc(w_prev_nxt);
              r_fix_rst    <= idx2jc(w_prev_nxt);
`endif
            end
          end
          default: r_state <= UNLOCKED;
        endcase
      end
    end
  end

  assign o_out_vld    = r_out_vld;
  assign o_idx        = r_idx;
  assign o_onehot     = r_onehot;
  assign o_legal      = r_legal;
  assign o_locked     = (r_state == LOCKED);
  assign o_err        = r_err;
  assign o_wrap       = r_wrap;
  assign o_err_cnt    = r_err_cnt;
`ifdef JOHNSON_DEC_RECOVER_EN
  assign o_fix_rst    = r_fix_rst;
  assign o_fix_preset = r_fix_preset;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
module tb_johnson_decoder;

  localparam logic [3:0] CODES [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                       4'b1111, 4'b0111, 4'b0011, 4'b0001};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i_jc = 4'b0000;
  logic       i_jc_vld = 1'b0;
  logic       o_out_vld;
  logic [2:0] o_idx;
  logic [7:0] o_onehot;
  logic       o_legal;
  logic       o_locked;
  logic       o_err;
  logic       o_wrap;
  logic [7:0] o_err_cnt;
`ifdef JOHNSON_DEC_RECOVER_EN
  logic [3:0] o_fix_rst;
  logic [3:0] o_fix_preset;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  johnson_decoder #(.LOCK_CNT(3), .ERR_W(8)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_jc      (i_jc),
    .i_jc_vld  (i_jc_vld),
    .o_out_vld (o_out_vld),
    .o_idx     (o_idx),
    .o_onehot  (o_onehot),
    .o_legal   (o_legal),
    .o_locked  (o_locked),
    .o_err     (o_err),
    .o_wrap    (o_wrap),
    .o_err_cnt (o_err_cnt)
`ifdef JOHNSON_DEC_RECOVER_EN
    ,
    .o_fix_rst    (o_fix_rst),
    .o_fix_preset (o_fix_preset)
`endif
  );

  // Reference model: legality and index come from a lookup in the code table.
  function automatic int lookup(input logic [3:0] jc);
    for (int i = 0; i < 8; i++) if (CODES[i] == jc) return i;
    return -1;
  endfunction

  int       m_prev = 0;
  bit       m_prev_vld = 0;
  int       m_run = 0;
  bit       e_locked = 0;
  int       e_cnt = 0;
  bit       e_out_vld = 0;
  int       e_idx = 0;
  bit [7:0] e_onehot = '0;
  bit       e_legal = 0;
  bit       e_err = 0;
  bit       e_wrap = 0;

  always @(posedge clk or negedge rst_n) begin
    int  k;
    bit  good;
    if (!rst_n) begin
      m_prev <= 0; m_prev_vld <= 0; m_run <= 0; e_locked <= 0; e_cnt <= 0;
      e_out_vld <= 0; e_idx <= 0; e_onehot <= '0; e_legal <= 0;
      e_err <= 0; e_wrap <= 0;
    end else begin
      e_out_vld <= i_jc_vld;
      e_err     <= 0;
      e_wrap    <= 0;
      if (i_jc_vld) begin
        k = lookup(i_jc);
        good = (k >= 0) && (!m_prev_vld || k == (m_prev + 1) % 8 || k == m_prev);
        e_legal  <= (k >= 0);
        e_idx    <= (k >= 0) ? k : 0;
        e_onehot <= (k >= 0) ? (8'd1 << k) : 8'd0;
        e_wrap   <= good && m_prev_vld && m_prev == 7 && k == 0;
        if (k >= 0) begin
          m_prev     <= k;
          m_prev_vld <= 1;
        end
        if (!e_locked) begin
          if (good) begin
            m_run <= m_run + 1;
            if (m_run + 1 >= 3) e_locked <= 1;
          end else begin
            m_run <= 0;
          end
        end else if (!good) begin
          e_err    <= 1;
          e_cnt    <= (e_cnt < 255) ? e_cnt + 1 : 255;
          m_run    <= 0;
          e_locked <= 0;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      cmp("m_out_vld", int'(o_out_vld), int'(e_out_vld));
      cmp("m_idx",     int'(o_idx),     e_idx);
      cmp("m_onehot",  int'(o_onehot),  int'(e_onehot));
      cmp("m_legal",   int'(o_legal),   int'(e_legal));
      cmp("m_locked",  int'(o_locked),  int'(e_locked));
      cmp("m_err",     int'(o_err),     int'(e_err));
      cmp("m_wrap",    int'(o_wrap),    int'(e_wrap));
      cmp("m_err_cnt", int'(o_err_cnt), e_cnt);
    end
  end

  task automatic send(input logic [3:0] jc);
    @(negedge clk);
    i_jc = jc;
    i_jc_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_jc_vld = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    cmp({tag, "_out_vld"}, int'(o_out_vld), 0);
    cmp({tag, "_idx"},     int'(o_idx),     0);
    cmp({tag, "_onehot"},  int'(o_onehot),  0);
    cmp({tag, "_legal"},   int'(o_legal),   0);
    cmp({tag, "_locked"},  int'(o_locked),  0);
    cmp({tag, "_err"},     int'(o_err),     0);
    cmp({tag, "_wrap"},    int'(o_wrap),    0);
    cmp({tag, "_err_cnt"}, int'(o_err_cnt), 0);
  endtask

  initial begin
    int cur;
    int r;
    logic [3:0] jc;

    // Reset state
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Full sequence, then wrap back to 0000
    for (int k = 0; k < 8; k++) begin
      send(CODES[k]);
      cmp("seq_idx", int'(o_idx), k);
      cmp("seq_locked", int'(o_locked), (k >= 2) ? 1 : 0);
    end
    send(4'b0000);
    cmp("seq_wrap", int'(o_wrap), 1);
    cmp("seq_wrap_idx", int'(o_idx), 0);

    // Illegal code while locked
    send(4'b1000);
    send(4'b1100);
    send(4'b1010);
    cmp("ill_legal", int'(o_legal), 0);
    cmp("ill_onehot", int'(o_onehot), 0);
    cmp("ill_err", int'(o_err), 1);
    cmp("ill_err_cnt", int'(o_err_cnt), 1);
    cmp("ill_locked", int'(o_locked), 0);
    send(4'b1110);
    cmp("after_ill_idx", int'(o_idx), 3);
    cmp("after_ill_err", int'(o_err), 0);
    cmp("after_ill_locked", int'(o_locked), 0);

    // Relock, walk to idx 2, then skip to idx 4
    send(4'b1111);
    send(4'b0111);
    cmp("relock", int'(o_locked), 1);
    send(4'b0011); send(4'b0001); send(4'b0000); send(4'b1000); send(4'b1100);
    send(4'b1111);
    cmp("skip_err", int'(o_err), 1);
    cmp("skip_err_cnt", int'(o_err_cnt), 2);
    cmp("skip_locked", int'(o_locked), 0);
    cmp("skip_idx", int'(o_idx), 4);

    // Hold 1100 then a valid gap
    repeat (5) begin
      send(4'b1100);
      cmp("hold_err", int'(o_err), 0);
    end
    cmp("hold_locked", int'(o_locked), 1);
    idle(3);
    cmp("gap_out_vld", int'(o_out_vld), 0);
    cmp("gap_idx", int'(o_idx), 2);
    cmp("gap_legal", int'(o_legal), 1);
    cmp("gap_locked", int'(o_locked), 1);

    // Asynchronous reset mid-stream while locked
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    send(4'b0011);
    cmp("post_rst_legal", int'(o_legal), 1);
    cmp("post_rst_idx", int'(o_idx), 6);
    cmp("post_rst_onehot", int'(o_onehot), 8'b0100_0000);
    cmp("post_rst_err", int'(o_err), 0);

    // 300 locked errors, relocking in between
    cur = 6;
    for (int i = 0; i < 300; i++) begin
      repeat (3) begin
        cur = (cur + 1) % 8;
        send(CODES[cur]);
      end
      send(4'b1010);
      if (i == 9) cmp("sat_cnt10", int'(o_err_cnt), 10);
    end
    cmp("sat_cnt", int'(o_err_cnt), 255);

    // Randomized traffic checked against the model
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      jc = CODES[cur];
      if (r >= 1 && r <= 5) begin
        cur = (cur + 1) % 8;
        jc = CODES[cur];
      end else if (r == 8) begin
        cur = $urandom_range(0, 7);
        jc = CODES[cur];
      end else if (r == 9) begin
        jc = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      i_jc = jc;
      i_jc_vld = (r != 0);
    end
    @(negedge clk);
    i_jc_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
